// File: rtl/vga_overlay_pkg.sv
// Purpose: shared glyph geometry, glyph codes and the rgb332 pixel type for the numeric overlay.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_overlay_pkg;

    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 16;

    // Font ROM glyph codes: 0-9 are the digits themselves.
    localparam logic [3:0] GLYPH_BLANK = 4'd10;
    localparam logic [3:0] GLYPH_DASH  = 4'd11;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

endpackage

// File: rtl/overlay_field_hit.sv
// Purpose: hit test and glyph selection for one numeric field at the current pixel.
// Latency: purely combinational.
// Backpressure: none, evaluated every pixel.
// Ports: i_x/i_y/i_en/i_lz/i_bcd field shadow values, i_hcnt/i_vcnt counters;
//        o_hit pixel inside field, o_col/o_row position in glyph, o_glyph font code.
module overlay_field_hit #(
    parameter int DIGITS = 6
) (
    input  logic [9:0]          i_x,
    input  logic [9:0]          i_y,
    input  logic                i_en,
    input  logic                i_lz,
    input  logic [9:0]          i_hcnt,
    input  logic [9:0]          i_vcnt,
    input  logic [DIGITS*4-1:0] i_bcd,
    output logic                o_hit,
    output logic [3:0]          o_col,
    output logic [3:0]          o_row,
    output logic [3:0]          o_glyph
);
    import vga_overlay_pkg::*;

    // Bounds are compared in 11 bits so a field near column 1023 clips
    // instead of wrapping back onto the left edge of the screen.
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic [9:0]  w_dx;
    logic [3:0]  w_nib;
    logic [3:0]  w_code;
    logic        w_lead;

    assign w_x_end = {1'b0, i_x} + 11'(DIGITS * GLYPH_W);
    assign w_y_end = {1'b0, i_y} + 11'(GLYPH_H);

    assign o_hit = i_en
                && ({1'b0, i_hcnt} >= {1'b0, i_x}) && ({1'b0, i_hcnt} < w_x_end)
                && ({1'b0, i_vcnt} >= {1'b0, i_y}) && ({1'b0, i_vcnt} < w_y_end);

    assign w_dx  = i_hcnt - i_x;
    assign o_col = w_dx[3:0];
    assign o_row = i_vcnt[3:0] - i_y[3:0];

    // w_lead stays set while every digit so far (from the left) is zero.
    always_comb begin
        w_lead  = 1'b1;
        w_nib   = 4'd0;
        w_code  = GLYPH_BLANK;
        o_glyph = GLYPH_BLANK;
        for (int d = 0; d < DIGITS; d++) begin
            w_nib = i_bcd[d*4 +: 4];
            if (w_nib > 4'd9)
                w_code = GLYPH_DASH;
            else if (i_lz && w_lead && (w_nib == 4'd0) && (d != DIGITS - 1))
                w_code = GLYPH_BLANK;
            else
                w_code = w_nib;
            if (w_nib != 4'd0)
                w_lead = 1'b0;
            if (w_dx[9:4] == 6'(d))
                o_glyph = w_code;
        end
    end

endmodule

// File: rtl/vga_numeric_overlay.sv
// Purpose: draws N_FIELDS frame-buffered numeric readouts over the background pixel stream.
// Latency: 2 cycles from counters/bg to RGB and vidon_out; font_addr is combinational.
// Backpressure: none, one pixel per clock; the font ROM must answer exactly one cycle later.
// Ports: i_hcnt/i_vcnt/i_vidon/i_bg_rgb pixel stream in; i_frame_start latches i_bcd_in,
//        i_field_x/y, i_field_en, i_lz_blank into shadows; o_font_addr/i_font_data font ROM;
//        o_red/o_green/o_blue/o_vidon_out pixel stream out.
module vga_numeric_overlay #(
    parameter int         N_FIELDS = 2,
    parameter int         DIGITS   = 6,
    parameter logic [7:0] FG_RGB   = 8'hFF
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_vidon,
    input  logic [9:0]                   i_hcnt,
    input  logic [9:0]                   i_vcnt,
    input  logic                         i_frame_start,
    input  logic [N_FIELDS*DIGITS*4-1:0] i_bcd_in,
    input  logic [N_FIELDS*10-1:0]       i_field_x,
    input  logic [N_FIELDS*10-1:0]       i_field_y,
    input  logic [N_FIELDS-1:0]          i_field_en,
    input  logic [N_FIELDS-1:0]          i_lz_blank,
    input  logic [7:0]                   i_bg_rgb,
    output logic [7:0]                   o_font_addr,
    input  logic [15:0]                  i_font_data,
    output logic [2:0]                   o_red,
    output logic [2:0]                   o_green,
    output logic [1:0]                   o_blue,
    output logic                         o_vidon_out
);
    import vga_overlay_pkg::*;

    // Shadow copies: only these drive the drawing, so live inputs never tear a frame.
    logic [N_FIELDS*DIGITS*4-1:0] r_bcd;
    logic [N_FIELDS*10-1:0]       r_x;
    logic [N_FIELDS*10-1:0]       r_y;
    logic [N_FIELDS-1:0]          r_en;
    logic [N_FIELDS-1:0]          r_lz;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bcd <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_en  <= '0;
            r_lz  <= '0;
        end else if (i_frame_start) begin
            r_bcd <= i_bcd_in;
            r_x   <= i_field_x;
            r_y   <= i_field_y;
            r_en  <= i_field_en;
            r_lz  <= i_lz_blank;
        end
    end

    logic       w_hit   [N_FIELDS];
    logic [3:0] w_col   [N_FIELDS];
    logic [3:0] w_row   [N_FIELDS];
    logic [3:0] w_glyph [N_FIELDS];

    for (genvar f = 0; f < N_FIELDS; f++) begin : g_field
        overlay_field_hit #(.DIGITS(DIGITS)) u_hit (
            .i_x     (r_x[f*10 +: 10]),
            .i_y     (r_y[f*10 +: 10]),
            .i_en    (r_en[f]),
            .i_lz    (r_lz[f]),
            .i_hcnt  (i_hcnt),
            .i_vcnt  (i_vcnt),
            .i_bcd   (r_bcd[f*DIGITS*4 +: DIGITS*4]),
            .o_hit   (w_hit[f]),
            .o_col   (w_col[f]),
            .o_row   (w_row[f]),
            .o_glyph (w_glyph[f])
        );
    end

    // Scan from highest index down so the lowest hitting field is the last writer.
    logic       w_sel_hit;
    logic [3:0] w_sel_col;
    logic [3:0] w_sel_row;
    logic [3:0] w_sel_glyph;

    always_comb begin
        w_sel_hit   = 1'b0;
        w_sel_col   = 4'd0;
        w_sel_row   = 4'd0;
        w_sel_glyph = 4'd0;
        for (int f = N_FIELDS - 1; f >= 0; f--) begin
            if (w_hit[f]) begin
                w_sel_hit   = 1'b1;
                w_sel_col   = w_col[f];
                w_sel_row   = w_row[f];
                w_sel_glyph = w_glyph[f];
            end
        end
    end

    assign o_font_addr = w_sel_hit ? {w_sel_glyph, w_sel_row} : 8'h00;

    // Stage 1 waits alongside the ROM read; stage 2 merges glyph bit with background.
    logic       r_hit;
    logic [3:0] r_col;
    rgb332_t    r_bg;
    logic       r_vid;
    rgb332_t    r_rgb;
    logic       r_vid_out;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hit     <= 1'b0;
            r_col     <= 4'd0;
            r_bg      <= '0;
            r_vid     <= 1'b0;
            r_rgb     <= '0;
            r_vid_out <= 1'b0;
        end else begin
            r_hit     <= w_sel_hit;
            r_col     <= w_sel_col;
            r_bg      <= rgb332_t'(i_bg_rgb);
            r_vid     <= i_vidon;
            r_vid_out <= r_vid;
            if (!r_vid)
                r_rgb <= '0;
            else if (r_hit && i_font_data[4'd15 - r_col])
                r_rgb <= rgb332_t'(FG_RGB);
            else
                r_rgb <= r_bg;
        end
    end

    assign o_red       = r_rgb.r;
    assign o_green     = r_rgb.g;
    assign o_blue      = r_rgb.b;
    assign o_vidon_out = r_vid_out;

endmodule

// File: tb/tb_vga_numeric_overlay.sv
// Purpose: self-checking bench for vga_numeric_overlay against a pixel-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_numeric_overlay;
    localparam int         NF = 2;
    localparam int         ND = 6;
    localparam logic [7:0] FG = 8'hFF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vidon = 1'b0;
    logic              frame_start = 1'b0;
    logic [9:0]        hcnt = '0;
    logic [9:0]        vcnt = '0;
    logic [NF*ND*4-1:0] bcd_in = '0;
    logic [NF*10-1:0]  field_x = '0;
    logic [NF*10-1:0]  field_y = '0;
    logic [NF-1:0]     field_en = '0;
    logic [NF-1:0]     lz_blank = '0;
    logic [7:0]        bg = '0;
    logic [7:0]        font_addr;
    logic [15:0]       font_data = '0;
    logic [2:0]        red;
    logic [2:0]        green;
    logic [1:0]        blue;
    logic              vidon_out;

    vga_numeric_overlay #(.N_FIELDS(NF), .DIGITS(ND), .FG_RGB(FG)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_vidon       (vidon),
        .i_hcnt        (hcnt),
        .i_vcnt        (vcnt),
        .i_frame_start (frame_start),
        .i_bcd_in      (bcd_in),
        .i_field_x     (field_x),
        .i_field_y     (field_y),
        .i_field_en    (field_en),
        .i_lz_blank    (lz_blank),
        .i_bg_rgb      (bg),
        .o_font_addr   (font_addr),
        .i_font_data   (font_data),
        .o_red         (red),
        .o_green       (green),
        .o_blue        (blue),
        .o_vidon_out   (vidon_out)
    );

    always #5 clk = ~clk;

    // Arbitrary but glyph/row dependent font contents; synchronous one-cycle read.
    function automatic logic [15:0] rom(input logic [7:0] a);
        return {a ^ 8'h3C, {a[3:0], a[7:4]} ^ 8'hC5};
    endfunction

    always @(posedge clk) font_data <= rom(font_addr);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int   sh_x   [NF];
    int   sh_y   [NF];
    int   sh_bcd [NF][ND];
    bit   sh_en  [NF];
    bit   sh_lz  [NF];
    logic [8:0] m_s1 = '0;
    logic [8:0] m_out = '0;
    bit   started = 0;

    function automatic int mglyph(int f, int d);
        int nib = sh_bcd[f][d];
        if (nib > 9) return 11;
        if (sh_lz[f] && d != ND - 1 && nib == 0) begin
            bit lead = 1;
            for (int j = 0; j < d; j++) if (sh_bcd[f][j] != 0) lead = 0;
            if (lead) return 10;
        end
        return nib;
    endfunction

    function automatic int mfield(int hc, int vc);
        for (int f = 0; f < NF; f++)
            if (sh_en[f] && hc >= sh_x[f] && hc < sh_x[f] + ND * 16
                         && vc >= sh_y[f] && vc < sh_y[f] + 16)
                return f;
        return -1;
    endfunction

    function automatic int maddr(int hc, int vc);
        int f = mfield(hc, vc);
        if (f < 0) return 0;
        return mglyph(f, (hc - sh_x[f]) / 16) * 16 + (vc - sh_y[f]);
    endfunction

    function automatic logic [8:0] mpix(int hc, int vc, bit vid, logic [7:0] b);
        int f;
        logic [15:0] bits;
        if (!vid) return 9'h000;
        f = mfield(hc, vc);
        if (f >= 0) begin
            bits = rom(8'(maddr(hc, vc)));
            if (bits[15 - ((hc - sh_x[f]) % 16)]) return {1'b1, FG};
        end
        return {1'b1, b};
    endfunction

    always @(posedge clk) begin
        logic [8:0] p;
        p = mpix(int'(hcnt), int'(vcnt), vidon, bg);
        if (rst) begin
            m_out = '0;
            m_s1  = '0;
            for (int f = 0; f < NF; f++) begin
                sh_x[f] = 0; sh_y[f] = 0; sh_en[f] = 0; sh_lz[f] = 0;
                for (int d = 0; d < ND; d++) sh_bcd[f][d] = 0;
            end
        end else begin
            m_out = m_s1;
            m_s1  = p;
            if (frame_start) begin
                for (int f = 0; f < NF; f++) begin
                    sh_x[f]  = int'(field_x[f*10 +: 10]);
                    sh_y[f]  = int'(field_y[f*10 +: 10]);
                    sh_en[f] = field_en[f];
                    sh_lz[f] = lz_blank[f];
                    for (int d = 0; d < ND; d++) sh_bcd[f][d] = int'(bcd_in[(f*ND+d)*4 +: 4]);
                end
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("font_addr", int'(font_addr), maddr(int'(hcnt), int'(vcnt)));
            chk("rgb", int'({red, green, blue}), int'(m_out[7:0]));
            chk("vidon_out", int'(vidon_out), int'(m_out[8]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_field(int f, int x, int y, bit en, bit lz, logic [23:0] v);
        field_x[f*10 +: 10] = 10'(x);
        field_y[f*10 +: 10] = 10'(y);
        field_en[f] = en;
        lz_blank[f] = lz;
        for (int d = 0; d < ND; d++) bcd_in[(f*ND+d)*4 +: 4] = v[(ND-1-d)*4 +: 4];
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic probe(int h, int v, int exp, string nm);
        hcnt = 10'(h);
        vcnt = 10'(v);
        #1;
        chk(nm, int'(font_addr), exp);
    endtask

    task automatic scan(int v0, int v1, int h0, int h1);
        vidon = 1'b1;
        for (int v = v0; v <= v1; v++)
            for (int h = h0; h <= h1; h++) begin
                hcnt = 10'(h);
                vcnt = 10'(v);
                bg   = 8'($urandom);
                tick();
            end
        vidon = 1'b0;
    endtask

    task automatic rand_fields();
        logic [23:0] v;
        for (int f = 0; f < NF; f++) begin
            for (int d = 0; d < ND; d++)
                v[d*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            set_field(f, ($urandom_range(0, 3) == 0) ? $urandom_range(900, 1023) : $urandom_range(0, 200),
                      $urandom_range(0, 40), $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), v);
        end
    endtask

    initial begin
        // Reset with active video; live field inputs set but not yet latched.
        vidon = 1'b1; bg = 8'h1C; hcnt = 10'd300; vcnt = 10'd300;
        set_field(0, 290, 290, 1'b1, 1'b0, 24'h888888);
        repeat (3) begin
            tick();
            chk("rst_rgb", int'({red, green, blue}), 0);
            chk("rst_vidon", int'(vidon_out), 0);
        end
        rst = 1'b0;
        tick(); tick();
        chk("post_rst_bg", int'({red, green, blue}), 'h1C);
        chk("post_rst_vid", int'(vidon_out), 1);
        chk("post_rst_addr", int'(font_addr), 0);

        // Leading-zero blanking on 000123.
        vidon = 1'b0;
        set_field(0, 64, 32, 1'b1, 1'b1, 24'h000123);
        set_field(1, 0, 0, 1'b0, 1'b0, 24'h0);
        pulse_fs();
        probe(69, 35, 'hA3, "lz_d0");
        probe(96, 35, 'hA3, "lz_d2");
        probe(112, 35, 'h13, "d3");
        probe(135, 40, 'h28, "d4");
        probe(159, 47, 'h3F, "d5");
        probe(160, 35, 0, "right_edge");
        probe(63, 35, 0, "left_edge");
        probe(70, 48, 0, "bottom_edge");
        probe(70, 31, 0, "top_edge");
        // rom(8'h13) = 16'h2FF4: col 2 lit, col 0 dark.
        vidon = 1'b1; bg = 8'h00; hcnt = 10'd114; vcnt = 10'd35;
        tick(); tick();
        chk("fg_pixel", int'({red, green, blue}), 'hFF);
        bg = 8'h1C; hcnt = 10'd112;
        tick(); tick();
        chk("dark_pixel", int'({red, green, blue}), 'h1C);
        vidon = 1'b0;
        scan(30, 49, 60, 165);

        // All zeros, without and with blanking.
        set_field(0, 64, 32, 1'b1, 1'b0, 24'h000000);
        pulse_fs();
        probe(69, 33, 'h01, "zero_d0");
        probe(145, 33, 'h01, "zero_d5");
        scan(32, 35, 64, 160);
        set_field(0, 64, 32, 1'b1, 1'b1, 24'h000000);
        pulse_fs();
        probe(69, 33, 'hA1, "zero_lz_d0");
        probe(145, 33, 'h01, "zero_lz_d5");
        scan(32, 35, 64, 160);

        // Out-of-range nibble.
        set_field(0, 64, 32, 1'b1, 1'b0, 24'h12C456);
        pulse_fs();
        probe(99, 34, 'hB2, "dash_d2");
        probe(80, 34, 'h22, "d1");
        probe(112, 34, 'h42, "d3");
        scan(32, 47, 64, 160);

        // Overlap: field 0 wins.
        set_field(0, 100, 100, 1'b1, 1'b0, 24'h111111);
        set_field(1, 100, 104, 1'b1, 1'b0, 24'h777777);
        pulse_fs();
        probe(105, 106, 'h16, "overlap_f0");
        probe(105, 118, 'h7E, "below_f0_f1");
        scan(98, 121, 96, 200);

        // Clipping at the right edge.
        set_field(0, 0, 0, 1'b0, 1'b0, 24'h0);
        set_field(1, 1000, 200, 1'b1, 1'b0, 24'h987654);
        pulse_fs();
        probe(1000, 205, 'h95, "clip_d0");
        probe(1023, 205, 'h85, "clip_d1");
        probe(5, 205, 0, "no_wrap");
        probe(70, 205, 0, "no_wrap2");
        scan(200, 216, 990, 1023);
        scan(200, 216, 0, 100);

        // Live change mid-frame stays invisible until frame_start.
        set_field(1, 0, 0, 1'b0, 1'b0, 24'h0);
        set_field(0, 64, 32, 1'b1, 1'b1, 24'h000042);
        pulse_fs();
        scan(32, 39, 64, 160);
        set_field(0, 64, 32, 1'b1, 1'b1, 24'h000999);
        scan(40, 47, 64, 160);
        probe(144, 45, 'h2D, "old_value");
        pulse_fs();
        probe(144, 45, 'h9D, "new_value");

        // frame_start on a hit pixel: switch at the following pixel.
        set_field(0, 64, 32, 1'b1, 1'b1, 24'h000111);
        vidon = 1'b1; frame_start = 1'b1;
        probe(144, 40, 'h98, "fs_same_pixel");
        tick();
        frame_start = 1'b0;
        probe(145, 40, 'h18, "fs_next_pixel");
        repeat (4) tick();
        vidon = 1'b0;

        // Randomized traffic including resets and frame_starts.
        for (int i = 0; i < 6000; i++) begin
            if (i % 300 == 0) rand_fields();
            frame_start = ($urandom_range(0, 39) == 0);
            rst   = ($urandom_range(0, 699) == 0);
            vidon = ($urandom_range(0, 7) != 0);
            hcnt  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 330));
            vcnt  = 10'($urandom_range(0, 60));
            bg    = 8'($urandom);
            tick();
        end
        rst = 1'b0; frame_start = 1'b0; vidon = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_numeric_overlay.md
# vga_numeric_overlay

Parametrised numeric-readout overlay for the VGA path. It draws N_FIELDS fields of DIGITS 16x16 glyphs each (for example frequency and Vpp) over an incoming background pixel. Glyphs come from one shared synchronous font ROM. All field values and positions are double-buffered at frame boundaries, so the readout never tears. It sits between the sync generator / background renderer and the RGB output pins, and generalises the fixed per-digit sprite logic into one configurable pipelined block.

## Interface
Parameters:
- N_FIELDS, 2: number of independent numeric fields.
- DIGITS, 6: digits per field; field width is DIGITS*16 px.
- FG_RGB, 8'hFF: foreground colour {r[2:0],g[2:0],b[1:0]} for lit glyph pixels.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- vidon  in  1  active-video flag, aligned with hcnt/vcnt.
- hcnt  in  10  horizontal pixel counter.
- vcnt  in  10  vertical line counter.
- frame_start  in  1  one-cycle pulse in vertical blanking; latches the shadow registers.
- bcd_in  in  N_FIELDS*DIGITS*4  field f, digit d at [(f*DIGITS+d)*4 +: 4]; d=0 is leftmost.
- field_x  in  N_FIELDS*10  left column of each field.
- field_y  in  N_FIELDS*10  top line of each field.
- field_en  in  N_FIELDS  per-field display enable.
- lz_blank  in  N_FIELDS  per-field leading-zero blanking enable.
- bg_rgb  in  8  background pixel, aligned with hcnt/vcnt.
- font_addr  out  8  {glyph[3:0], row[3:0]} to the font ROM; combinational from the counters.
- font_data  in  16  ROM row, valid one cycle after font_addr; bit 15 is the leftmost column.
- red  out  3  output colour.
- green  out  3  output colour.
- blue  out  2  output colour.
- vidon_out  out  1  vidon delayed to align with RGB.

## Operation
- Shadow registers hold bcd, x, y, en and lz for each field.
  - Loaded only in the cycle after frame_start is sampled high.
  - Reset value 0, so nothing is drawn until the first frame_start after reset.
- Glyph codes come from the package:
  - 0-9: digits.
  - GLYPH_BLANK = 10.
  - GLYPH_DASH = 11, used for any BCD nibble > 9.
- Leading-zero blanking (lz=1): zero digits to the left of the first nonzero digit map to GLYPH_BLANK. Digit DIGITS-1 is never blanked.
- Hit test for field f:
  - Horizontal: x ≤ hcnt < x + DIGITS*16, evaluated in 11 bits so it never wraps. Parts of a field past 1023 are clipped.
  - Vertical: y ≤ vcnt < y + 16.
  - Field must have en=1.
  - If fields overlap, the lowest index wins.
- For the hit field: dx = hcnt - x; digit = dx>>4; col = dx[3:0]; row = (vcnt - y)[3:0].
- font_addr = {glyph(digit), row} on a hit, otherwise 8'h00.
- Stage 1 registers hit, col, bg_rgb and vidon.
- Stage 2 output:
  - If vidon_d = 0: RGB = 0.
  - Else if hit_d and font_data[15-col_d]: RGB = FG_RGB.
  - Otherwise: RGB = bg_d.

## Timing
- Latency: counters and bg presented in cycle n produce RGB and vidon_out valid in cycle n+2. Throughput is one pixel per clock with no stalls.
- Reset:
  - red/green/blue = 0 and vidon_out = 0 on the first edge with rst=1.
  - Pipeline hit flags are cleared and the shadow registers are zeroed.
  - Reset mid-frame blanks the overlay until the next frame_start; bg is also gated because vidon_d is cleared.
- frame_start coinciding with a visible pixel: that pixel uses the old shadow values; the new values apply from the next pixel onward.
- Live inputs (bcd_in etc.) may change at any time without visible effect before the next frame_start.
- font_data is sampled exactly one cycle after font_addr; any other ROM latency is unsupported.

## Structure
- Package vga_overlay_pkg holds:
  - GLYPH_W = 16, GLYPH_H = 16.
  - GLYPH_BLANK, GLYPH_DASH.
  - The packed rgb332 typedef.
- Sub-module overlay_field_hit, instantiated N_FIELDS times:
  - Inputs: shadow x, y, en, the counters, and the field's digit nibbles.
  - Outputs: hit, col, row, glyph code (includes the leading-zero logic).
- The top level contains:
  - The shadow registers.
  - Priority selection across fields.
  - The 2-stage pipeline.

## Test plan
- Reset with rst=1 for 3 cycles while vidon=1 and bg=8'h1C → RGB = 0 and vidon_out = 0 during reset. After release, before any frame_start, the output equals bg (8'h1C) two cycles later. No field is drawn.
- Field 0: x=64, y=32, bcd=000123, lz=1, frame_start pulse, behavioural ROM → font_addr glyph is 10 for digits 0-2 and 1, 2, 3 for digits 3-5. Glyph pixels render FG 8'hFF exactly 2 cycles after the matching hcnt.
- Same field with lz=0 and bcd=000000 → six '0' glyphs. With lz=1 → only the rightmost '0' is drawn.
- Nibble 4'hC in digit 2 → glyph code 11 on that digit only.
- Fields 0 and 1 overlapping at x=100, y=100 → field 0 glyphs are shown. Field 1 with x=1000 is clipped at hcnt 1023 with no wraparound to hcnt 0-xx.
- Change bcd_in mid-frame, with frame_start at the end of the frame → the current frame is unchanged and the next frame shows the new value. Check that a frame_start pulse during an active hit switches the value exactly at the following pixel.
